// File: rtl/magnitude_search_4.sv
`default_nettype none
// ============================================================================
// Module      : magnitude_search_4
// Description : Binary-searches a hidden 4-bit target through an external
//               magnitude comparator's one-hot result code.
// Revision    : 1.0 - initial release
// ============================================================================
module magnitude_search_4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] Y,
  output logic [3:0] B,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic       err,
  output logic [3:0] result,
  output logic [2:0] probes
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } state_t;

  localparam logic [2:0] c_Y_GT = 3'b100;
  localparam logic [2:0] c_Y_EQ = 3'b010;
  localparam logic [2:0] c_Y_LT = 3'b001;

  state_t     r_state;
  logic [3:0] r_lo;
  logic [3:0] r_hi;
  logic [3:0] w_b_inc;
  logic [3:0] w_b_dec;

  // Midpoint is formed at 5 bits because lo+hi can reach 30.
  function automatic logic [3:0] mid(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4:1];
  endfunction

  assign w_b_inc = B + 4'd1;
  assign w_b_dec = B - 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_lo    <= 4'd0;
      r_hi    <= 4'd15;
      B       <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      found   <= 1'b0;
      err     <= 1'b0;
      result  <= 4'd0;
      probes  <= 3'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_lo    <= 4'd0;
            r_hi    <= 4'd15;
            B       <= 4'd7;
            probes  <= 3'd0;
            found   <= 1'b0;
            result  <= 4'd0;
            busy    <= 1'b1;
            r_state <= PROBE;
          end
        end
        PROBE: begin
          probes <= probes + 3'd1;
          // A collapsed range (B at the bound being moved past) means the
          // comparator contradicted itself; that also bounds the probe count.
          if (Y == c_Y_EQ) begin
            result  <= B;
            found   <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else if (Y == c_Y_GT && B != r_hi) begin
            r_lo <= w_b_inc;
            B    <= mid(w_b_inc, r_hi);
          end else if (Y == c_Y_LT && B != r_lo) begin
            r_hi <= w_b_dec;
            B    <= mid(r_lo, w_b_dec);
          end else begin
            err     <= 1'b1;
            done    <= 1'b1;
            found   <= 1'b0;
            result  <= 4'd0;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_magnitude_search_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_magnitude_search_4
// Description : Directed, table-driven bench for magnitude_search_4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_magnitude_search_4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] Y;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic       found;
  logic       err;
  logic [3:0] result;
  logic [2:0] probes;

  logic [3:0] tgt;
  logic       fen;
  logic [2:0] fy;

  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    logic [3:0] target;
    logic       fen;
    logic [2:0] fy;
    logic       exp_found;
    logic       exp_err;
    logic [3:0] exp_result;
    int         exp_probes;
  } vec_t;

  vec_t vecs[$];

  magnitude_search_4 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .Y      (Y),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result),
    .probes (probes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model with target on A, optionally overridden by a forced code.
  always_comb begin
    Y = 3'b000;
    if (fen)          Y = fy;
    else if (tgt > B) Y = 3'b100;
    else if (tgt == B) Y = 3'b010;
    else              Y = 3'b001;
  end

  task automatic check(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_search(input vec_t v);
    int  lat;
    bit  seen;
    tgt = v.target;
    fen = v.fen;
    fy  = v.fy;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_B", B, 7);
    check("start_busy", busy, 1);
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    check("latency", lat, v.exp_probes);
    check("found", found, v.exp_found);
    check("err", err, v.exp_err);
    check("result", result, v.exp_result);
    check("probes", probes, v.exp_probes);
    check("busy_end", busy, 0);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("err_pulse", err, 0);
  endtask

  task automatic wait_done(input string name, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    if (!seen) check(name, 0, 1);
  endtask

  initial begin
    int exp_p[16] = '{4, 3, 4, 2, 4, 3, 4, 1, 4, 3, 4, 2, 4, 3, 4, 5};
    int b15[5]    = '{7, 11, 13, 14, 15};
    int b10[4]    = '{7, 11, 9, 10};
    int lat;

    for (int t = 0; t < 16; t++)
      vecs.push_back('{target: 4'(t), fen: 1'b0, fy: 3'b000, exp_found: 1'b1,
                       exp_err: 1'b0, exp_result: 4'(t), exp_probes: exp_p[t]});
    vecs.push_back('{4'd5, 1'b1, 3'b011, 1'b0, 1'b1, 4'd0, 1});
    vecs.push_back('{4'd5, 1'b1, 3'b000, 1'b0, 1'b1, 4'd0, 1});
    vecs.push_back('{4'd5, 1'b1, 3'b111, 1'b0, 1'b1, 4'd0, 1});
    vecs.push_back('{4'd5, 1'b1, 3'b100, 1'b0, 1'b1, 4'd0, 5});
    vecs.push_back('{4'd5, 1'b1, 3'b001, 1'b0, 1'b1, 4'd0, 4});

    rst   = 1'b1;
    start = 1'b0;
    tgt   = 4'd0;
    fen   = 1'b0;
    fy    = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("rst_B", B, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    check("rst_probes", probes, 0);

    foreach (vecs[i]) run_search(vecs[i]);

    // Target 15: walk the guess sequence up to the top of the range.
    tgt = 4'd15;
    fen = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("b15_seq", B, b15[k]);
      check("b15_done_low", done, 0);
      @(posedge clk); #1;
    end
    check("b15_done", done, 1);
    check("b15_result", result, 15);
    // Idle with start low must hold the outcome.
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold_result", result, 15);
    check("idle_hold_found", found, 1);
    check("idle_hold_probes", probes, 5);
    check("idle_hold_B", B, 15);

    // Target 10, asynchronous reset after two probes.
    tgt = 4'd10;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_B", B, 9);
    check("pre_rst_probes", probes, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_B", B, 0);
    check("arst_busy", busy, 0);
    check("arst_probes", probes, 0);
    check("arst_found", found, 0);
    @(negedge clk) rst = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      check("b10_seq", B, b10[k]);
      check("b10_busy", busy, 1);
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    check("b10_done", done, 1);
    check("b10_result", result, 10);
    check("b10_busy_low", busy, 0);
    // start still held: the restart lands on the edge after done.
    @(posedge clk); #1;
    check("restart_B", B, 7);
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    check("restart_probes", probes, 0);
    start = 1'b0;
    wait_done("restart_timeout", lat);
    check("restart_latency", lat, 4);
    check("restart_result", result, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
